apb_multi_requester: RTL
========================

# apb_multi_requester

Synthesizable APB requester that turns a single valid/ready command stream into APB transfers across `NUM_SLAVES` completers. Addresses are decoded into per-completer `psel` lines. Unaligned and unmapped requests are rejected locally with no bus activity. Each access phase is bounded by a wait-state timeout. Every command returns exactly one response on a valid/ready response channel. The block sits between the system interconnect and the APB peripheral segment, and is the synthesizable successor to the bench-driven bridge.

## Interface
Parameters:
- ADDR_WIDTH, 32, paddr / cmd_addr width
- DATA_WIDTH, 32, data width; must be 8, 16 or 32; STRB_WIDTH = DATA_WIDTH/8 is derived
- NUM_SLAVES, 4, completer count, power of two, ≥2; SEL_BITS = clog2(NUM_SLAVES)
- REGION_BITS, 12, each completer owns 2^REGION_BITS bytes
- TIMEOUT, 16, maximum wait-state cycles in ACCESS before abort, ≥1

Ports. One clock; reset is asynchronous and active-high.
- pclk  in  1  clock
- preset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  STRB_WIDTH  write byte strobes
- cmd_prot  in  3  pprot value
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  any error
- rsp_decerr  out  1  unaligned or unmapped; no bus transfer occurred
- rsp_timeout  out  1  transfer aborted after TIMEOUT wait cycles
- psel  out  NUM_SLAVES  one-hot completer select
- penable, pwrite  out  1  APB control
- paddr  out  ADDR_WIDTH  APB address
- pwdata  out  DATA_WIDTH  APB write data
- pstrb  out  STRB_WIDTH  APB strobes; 0 on reads
- pprot  out  3  APB protection
- pready, pslverr  in  NUM_SLAVES  per-completer responses
- prdata  in  NUM_SLAVES*DATA_WIDTH  per-completer read data; completer i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On acceptance, register addr, write, wdata, strb and prot. Compute:
  - idx = cmd_addr[REGION_BITS +: SEL_BITS]
  - unmapped = any cmd_addr bit above REGION_BITS+SEL_BITS-1 is set
  - unaligned = cmd_addr[clog2(STRB_WIDTH)-1:0] != 0
  - If unmapped or unaligned, go to RESP with err=1, decerr=1. Otherwise go to SETUP.
- SETUP: psel[idx]=1, penable=0; next state ACCESS.
- ACCESS: penable=1; wait counter increments each cycle in which pready[idx]=0.
  - pready[idx]=1: capture prdata slice idx as rdata (reads only), capture pslverr[idx] as err; go to RESP.
  - Counter reaches TIMEOUT with pready still low: go to RESP with err=1, timeout=1, rdata=0.
- RESP: all psel and penable are 0; rsp_valid=1 with fields held stable. On rsp_ready, go to IDLE.
- paddr, pwrite, pwdata, pstrb and pprot are held stable from SETUP through the last ACCESS cycle. pstrb is forced to 0 when pwrite=0.
- Only the selected completer's pready, pslverr and prdata are observed; all other inputs are ignored.

## Timing
- Reset values: all outputs 0 except cmd_ready=1. State is IDLE and the wait counter is 0.
- Reset asserted mid-transfer clears psel and penable immediately (asynchronous); any pending response is discarded.
- Zero-wait completer: acceptance edge → SETUP for 1 cycle → ACCESS for 1 cycle → rsp_valid on the following cycle. That is 3 cycles from acceptance to rsp_valid.
- Local error: rsp_valid asserts the cycle after acceptance; psel is never asserted.
- Timeout: ACCESS lasts exactly TIMEOUT+1 cycles; psel drops on the edge that enters RESP.
- Throughput: with rsp_ready held high, the next command is accepted the cycle after the response handshake. Minimum 4 cycles per transfer; no overlap between transfers.
- cmd_ready is low in SETUP, ACCESS and RESP. A cmd_valid arriving in those states waits.

## Test plan
- Zero-wait read of 0x0000_1004, completer 1 returns 0xDEADBEEF → psel=4'b0010 for 2 cycles; rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 3 cycles after acceptance.
- Write to 0x0000_3008 with wdata 0xFFFF_FFFF, strb 4'h1, and 2 wait states → psel=4'b1000; pwdata, pstrb and paddr stable for 4 cycles; rsp_err=0.
- Read of 0x0000_0003 and read of 0x0000_4000 → no psel activity for either; each gives rsp_err=1, rsp_decerr=1 one cycle after acceptance.
- Completer 2 holds pready low (TIMEOUT=16) → penable high for 17 cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Completer 0 returns pslverr=1 with pready=1 → rsp_err=1, rsp_decerr=0, rsp_timeout=0. Hold rsp_ready low for 5 cycles: cmd_ready stays 0 and response fields stay stable.
- preset pulsed during ACCESS → psel and penable are 0 before the next edge; after release, cmd_ready=1 and a fresh read completes normally.

Source files
------------

// File: rtl/apb_multi_requester.sv
// apb_multi_requester
//   Converts a valid/ready command stream into APB transfers spread over
//   NUM_SLAVES completers.
//   - Each completer owns a 2^REGION_BITS byte window.
//   - Unaligned or unmapped commands are answered locally, with no bus
//     activity.
//   - Each ACCESS phase is bounded by a TIMEOUT wait-state limit.
//   - Every command yields exactly one response on a valid/ready channel.
// Ports
//   pclk, preset                   clock, async active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_write/addr/wdata/strb/prot command payload
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata/err/decerr/timeout   response payload
//   psel/penable/pwrite/paddr/pwdata/pstrb/pprot   APB request outputs
//   pready/pslverr/prdata          per-completer APB responses
module apb_multi_requester #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_SLAVES  = 4,
  parameter int unsigned REGION_BITS = 12,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic                             pclk,
  input  logic                             preset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]          cmd_strb,
  input  logic [2:0]                       cmd_prot,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             rsp_decerr,
  output logic                             rsp_timeout,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [DATA_WIDTH/8-1:0]          pstrb,
  output logic [2:0]                       pprot,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned SEL_BITS   = $clog2(NUM_SLAVES);
  localparam int unsigned HI_LSB     = REGION_BITS + SEL_BITS;
  localparam int unsigned CNT_W      = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SEL_BITS-1:0]     idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
  logic [2:0]              pprot_q, pprot_d;
  logic [NUM_SLAVES-1:0]   psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_decerr_q, rsp_decerr_d;
  logic                    rsp_timeout_q, rsp_timeout_d;

  // Address decode of the offered command
  logic [SEL_BITS-1:0]     cmd_idx_c;
  logic                    cmd_bad_c;
  assign cmd_idx_c = cmd_addr[REGION_BITS +: SEL_BITS];
  assign cmd_bad_c = ((cmd_addr >> HI_LSB) != '0) ||
                     ((cmd_addr & ADDR_WIDTH'(STRB_WIDTH - 1)) != '0);

  // Selected completer's response; all other completers are ignored
  logic                    sel_ready_c, sel_err_c;
  logic [DATA_WIDTH-1:0]   sel_rdata_c;
  always_comb begin
    sel_ready_c = pready[idx_q];
    sel_err_c   = pslverr[idx_q];
    sel_rdata_c = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (idx_q == SEL_BITS'(i)) sel_rdata_c = prdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_decerr_d  = rsp_decerr_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          idx_d         = cmd_idx_c;
          paddr_d       = cmd_addr;
          pwrite_d      = cmd_write;
          pwdata_d      = cmd_wdata;
          pstrb_d       = cmd_write ? cmd_strb : '0;
          pprot_d       = cmd_prot;
          cmd_ready_d   = 1'b0;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b0;
          rsp_decerr_d  = 1'b0;
          rsp_timeout_d = 1'b0;
          cnt_d         = '0;
          if (cmd_bad_c) begin
            state_d      = S_RESP;
            rsp_valid_d  = 1'b1;
            rsp_err_d    = 1'b1;
            rsp_decerr_d = 1'b1;
          end else begin
            state_d = S_SETUP;
            psel_d  = NUM_SLAVES'(1) << cmd_idx_c;
          end
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        if (sel_ready_c) begin
          state_d     = S_RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_err_c;
          rsp_rdata_d = (pwrite_q || sel_err_c) ? '0 : sel_rdata_c;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          // This was the TIMEOUT-th wait cycle: abort the transfer
          state_d       = S_RESP;
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_decerr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_decerr_q  <= rsp_decerr_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_decerr  = rsp_decerr_q;
  assign rsp_timeout = rsp_timeout_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pprot       = pprot_q;

endmodule
